commit_monitor: RTL

Parametrised commit/trap monitor between the core's retire point and the Difftest commit, trap and counter interfaces. It accepts up to NR_COMMIT in-order retirements per cycle and registers them into per-lane commit records with skip and x0-write gating. It keeps cycle and retired-instruction counters, detects the trap opcode and a no-commit watchdog timeout, and then halts. It replaces the single-lane, instruction-per-cycle commit logic in the core top, which the upcoming multi-issue pipeline needs.

---
 rtl/commit_pkg.sv | 35 +++
 rtl/commit_monitor_if.sv | 50 +++++
 rtl/commit_lane.sv | 51 +++++
 rtl/commit_monitor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared definitions for the commit monitor slice.
//   TRAP_OPCODE          - inst[6:0] value that ends simulation
//   TIMEOUT_CODE_DEFAULT - trap code reported when the watchdog expires
//   state_e              - monitor FSM states
//   lane_rec_t           - one retired instruction as seen by Difftest
//   popcount8            - number of set bits in an 8-bit lane mask
package commit_pkg;

   localparam logic [6:0] TRAP_OPCODE          = 7'h6b;
   localparam logic [7:0] TIMEOUT_CODE_DEFAULT = 8'hFE;

   typedef enum logic [0:0] {
      RUN,
      HALTED
   } state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        wen;
      logic [4:0]  wdest;
      logic [63:0] wdata;
      logic        skip;
   } lane_rec_t;

   function automatic logic [3:0] popcount8(input logic [7:0] mask);
      logic [3:0] n;
      n = 4'd0;
      for (int unsigned i = 0; i < 8; i++) begin
         n = n + {3'b000, mask[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/commit_monitor_if.sv
// Retire-side and Difftest-side signal bundle of the commit monitor.
//   master : the core / environment (drives in_*, trap_a0; observes cmt_*, trap_*, counters)
//   slave  : the commit monitor
// Per-lane vectors are packed with lane 0 in the least significant slice.
interface commit_monitor_if #(
   parameter int unsigned NR_COMMIT = 2
);
   import commit_pkg::*;

   // retire point
   logic [NR_COMMIT-1:0]    in_valid;
   logic [NR_COMMIT*64-1:0] in_pc;
   logic [NR_COMMIT*32-1:0] in_inst;
   logic [NR_COMMIT-1:0]    in_wen;
   logic [NR_COMMIT*5-1:0]  in_wdest;
   logic [NR_COMMIT*64-1:0] in_wdata;
   logic [NR_COMMIT-1:0]    in_skip;
   logic [63:0]             trap_a0;

   // commit records
   logic [NR_COMMIT-1:0]    cmt_valid;
   logic [NR_COMMIT*64-1:0] cmt_pc;
   logic [NR_COMMIT*32-1:0] cmt_inst;
   logic [NR_COMMIT-1:0]    cmt_wen;
   logic [NR_COMMIT*8-1:0]  cmt_wdest;
   logic [NR_COMMIT*64-1:0] cmt_wdata;
   logic [NR_COMMIT-1:0]    cmt_skip;

   // trap, counters, status
   logic                    trap_valid;
   logic [7:0]              trap_code;
   logic [63:0]             trap_pc;
   logic [63:0]             cycle_cnt;
   logic [63:0]             instr_cnt;
   logic                    halted;
   logic                    proto_err;

   modport master (
      output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, trap_a0,
      input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip,
      input  trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, halted, proto_err
   );

   modport slave (
      input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, trap_a0,
      output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip,
      output trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, halted, proto_err
   );

endinterface

// File: rtl/commit_lane.sv
// One-lane commit register slice.
//   clock, reset : clock, asynchronous active-low reset
//   in_valid     : lane retires this cycle
//   kill         : drop the lane (above a trap, or monitor halted)
//   in_rec       : raw retire record
//   cmt_valid    : registered lane valid
//   cmt_rec      : registered record, wen gated for x0, skip forced at PC_START,
//                  all-zero when the lane is not committed
module commit_lane
   import commit_pkg::*;
#(
   parameter logic [63:0] PC_START = 64'h8000_0000
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      in_valid,
   input  logic      kill,
   input  lane_rec_t in_rec,
   output logic      cmt_valid,
   output lane_rec_t cmt_rec
);

   logic      valid_d, valid_q;
   lane_rec_t rec_d, rec_q;

   always_comb begin
      valid_d = in_valid & ~kill;
      rec_d   = '0;
      if (valid_d) begin
         rec_d       = in_rec;
         // Writes to x0 are architecturally dropped; Difftest must not see them.
         rec_d.wen   = in_rec.wen & (in_rec.wdest != 5'd0);
         // The reset-vector instruction is never compared against the reference.
         rec_d.skip  = in_rec.skip | (in_rec.pc == PC_START);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         rec_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rec_q   <= rec_d;
      end
   end

   assign cmt_valid = valid_q;
   assign cmt_rec   = rec_q;

endmodule

// File: rtl/commit_monitor.sv
// Multi-lane commit / trap monitor between the retire point and Difftest.
//   clock, reset : clock, asynchronous active-low reset
//   bus          : commit_monitor_if.slave
//                  in_*      up to NR_COMMIT in-order retirements per cycle, trap_a0 trap code source
//                  cmt_*     registered per-lane commit records (one cycle latency)
//                  trap_*    one-cycle trap pulse with held code / PC
//                  cycle_cnt, instr_cnt, halted, proto_err
module commit_monitor
   import commit_pkg::*;
#(
   parameter int unsigned NR_COMMIT    = 2,
   parameter logic [63:0] PC_START     = 64'h8000_0000,
   parameter int unsigned TIMEOUT      = 5000,
   parameter logic [7:0]  TIMEOUT_CODE = TIMEOUT_CODE_DEFAULT
) (
   input logic             clock,
   input logic             reset,
   commit_monitor_if.slave bus
);

   state_e      state_q;
   logic        trap_valid_q;
   logic [7:0]  trap_code_q;
   logic [63:0] trap_pc_q;
   logic [63:0] cycle_q;
   logic [63:0] instr_q;
   logic        halted_q;
   logic        proto_q;
   logic [31:0] wdog_q;
   logic [63:0] last_pc_q;

   logic [NR_COMMIT-1:0] run_valid;
   logic [NR_COMMIT-1:0] keep;
   logic [NR_COMMIT-1:0] commit_mask;
   logic                 trap_hit;
   logic [63:0]          trap_pc_sel;
   logic [63:0]          last_pc_sel;
   logic                 any_commit;
   logic                 lane_gap;
   logic [7:0]           mask8;
   logic [3:0]           commit_cnt;
   logic [31:0]          wdog_inc;
   logic                 wdog_expired;

   // Trap priority encoder: the lowest trapping lane and everything below it commit.
   always_comb begin
      run_valid   = (state_q == RUN) ? bus.in_valid : '0;
      keep        = '0;
      trap_hit    = 1'b0;
      trap_pc_sel = '0;
      last_pc_sel = last_pc_q;
      lane_gap    = 1'b0;
      for (int unsigned i = 0; i < NR_COMMIT; i++) begin
         keep[i] = ~trap_hit;
         if (!trap_hit && run_valid[i] && (bus.in_inst[i*32 +: 7] == TRAP_OPCODE)) begin
            trap_hit    = 1'b1;
            trap_pc_sel = bus.in_pc[i*64 +: 64];
         end
      end
      commit_mask = run_valid & keep;
      // Highest committed lane is the youngest instruction.
      for (int unsigned i = 0; i < NR_COMMIT; i++) begin
         if (commit_mask[i]) begin
            last_pc_sel = bus.in_pc[i*64 +: 64];
         end
      end
      for (int unsigned i = 1; i < NR_COMMIT; i++) begin
         if (run_valid[i] && !run_valid[i-1]) begin
            lane_gap = 1'b1;
         end
      end
      any_commit                = |commit_mask;
      mask8                     = '0;
      mask8[NR_COMMIT-1:0]      = commit_mask;
      commit_cnt                = popcount8(mask8);
      wdog_inc                  = wdog_q + 32'd1;
      wdog_expired              = ~any_commit & (wdog_inc == 32'(TIMEOUT));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= RUN;
         trap_valid_q <= 1'b0;
         trap_code_q  <= '0;
         trap_pc_q    <= '0;
         cycle_q      <= '0;
         instr_q      <= '0;
         halted_q     <= 1'b0;
         proto_q      <= 1'b0;
         wdog_q       <= '0;
         last_pc_q    <= PC_START;
      end else begin
         trap_valid_q <= 1'b0;
         unique case (state_q)
            RUN: begin
               cycle_q <= cycle_q + 64'd1;
               instr_q <= instr_q + 64'(commit_cnt);
               if (lane_gap) begin
                  proto_q <= 1'b1;
               end
               if (any_commit) begin
                  wdog_q    <= '0;
                  last_pc_q <= last_pc_sel;
               end else begin
                  wdog_q <= wdog_inc;
               end
               if (trap_hit) begin
                  trap_valid_q <= 1'b1;
                  trap_code_q  <= bus.trap_a0[7:0];
                  trap_pc_q    <= trap_pc_sel;
                  halted_q     <= 1'b1;
                  state_q      <= HALTED;
               end else if (wdog_expired) begin
                  trap_valid_q <= 1'b1;
                  trap_code_q  <= TIMEOUT_CODE;
                  trap_pc_q    <= last_pc_q;
                  halted_q     <= 1'b1;
                  state_q      <= HALTED;
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NR_COMMIT; g++) begin : g_lane
      lane_rec_t rec_in;
      lane_rec_t rec_out;
      logic      valid_out;

      assign rec_in = '{
         pc:    bus.in_pc[g*64 +: 64],
         inst:  bus.in_inst[g*32 +: 32],
         wen:   bus.in_wen[g],
         wdest: bus.in_wdest[g*5 +: 5],
         wdata: bus.in_wdata[g*64 +: 64],
         skip:  bus.in_skip[g]
      };

      commit_lane #(
         .PC_START (PC_START)
      ) u_lane (
         .clock     (clock),
         .reset     (reset),
         .in_valid  (bus.in_valid[g]),
         .kill      (~commit_mask[g]),
         .in_rec    (rec_in),
         .cmt_valid (valid_out),
         .cmt_rec   (rec_out)
      );

      assign bus.cmt_valid[g]          = valid_out;
      assign bus.cmt_pc[g*64 +: 64]    = rec_out.pc;
      assign bus.cmt_inst[g*32 +: 32]  = rec_out.inst;
      assign bus.cmt_wen[g]            = rec_out.wen;
      assign bus.cmt_wdest[g*8 +: 8]   = {3'b000, rec_out.wdest};
      assign bus.cmt_wdata[g*64 +: 64] = rec_out.wdata;
      assign bus.cmt_skip[g]           = rec_out.skip;
   end

   assign bus.trap_valid = trap_valid_q;
   assign bus.trap_code  = trap_code_q;
   assign bus.trap_pc    = trap_pc_q;
   assign bus.cycle_cnt  = cycle_q;
   assign bus.instr_cnt  = instr_q;
   assign bus.halted     = halted_q;
   assign bus.proto_err  = proto_q;

endmodule
